// File: rtl/display_pkg.sv
// display_pkg
// Shared glyph definitions for the 7-segment frame generator.
// A glyph is a 6-bit code: 0..9 are decimal digits, the letter constants
// below name the label glyphs, and GLYPH_BLANK switches a position off.
package display_pkg;

    typedef logic [5:0] glyph_t;

    localparam glyph_t GLYPH_BLANK = 6'h3F;

    localparam glyph_t GLYPH_A = 6'h0A;
    localparam glyph_t GLYPH_E = 6'h0E;
    localparam glyph_t GLYPH_J = 6'h13;
    localparam glyph_t GLYPH_N = 6'h17;
    localparam glyph_t GLYPH_O = 6'h18;
    localparam glyph_t GLYPH_P = 6'h19;
    localparam glyph_t GLYPH_R = 6'h1B;

endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial
// Serial double-dabble binary-to-BCD converter, one value bit per cycle,
// MSB first.
//   clock, reset_n : system clock, asynchronous active-low reset
//   start          : captures value and (re)starts a conversion, even mid-run
//   value          : unsigned binary input
//   busy           : high for exactly VALUE_WIDTH cycles after start
//   done           : one-cycle pulse after the last bit has been shifted in
//   bcd            : DIGITS packed BCD nibbles, digit 0 in the low nibble
//   carry          : sticky flag, the value needed more than DIGITS digits
module bin2bcd_serial #(
    parameter int VALUE_WIDTH = 32,
    parameter int DIGITS      = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [VALUE_WIDTH-1:0] value,
    output logic                   busy,
    output logic                   done,
    output logic [DIGITS*4-1:0]    bcd,
    output logic                   carry
);

    localparam int CW = $clog2(VALUE_WIDTH + 1);

    logic [VALUE_WIDTH-1:0] shift_q;
    logic [DIGITS*4-1:0]    bcd_q, bcd_d, adjusted;
    logic [CW-1:0]          count_q;
    logic                   busy_q, done_q, carry_q, carry_d;
    logic [3:0]             nibble;

    // Add-3 correction on every nibble >= 5, then shift in the next bit.
    // A bit leaving the top nibble is a decimal carry past DIGITS; dropping
    // it leaves the lower digits equal to the value modulo 10^DIGITS.
    always_comb begin
        adjusted = '0;
        nibble   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nibble = bcd_q[i*4 +: 4];
            adjusted[i*4 +: 4] = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
        end
        bcd_d   = {adjusted[DIGITS*4-2:0], shift_q[VALUE_WIDTH-1]};
        carry_d = carry_q | adjusted[DIGITS*4-1];
    end

    // Conversion sequencer; start always wins so a new load aborts a run
    // without ever producing a done for the aborted value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                shift_q <= value;
                bcd_q   <= '0;
                carry_q <= 1'b0;
                count_q <= CW'(VALUE_WIDTH);
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                shift_q <= shift_q << 1;
                bcd_q   <= bcd_d;
                carry_q <= carry_d;
                count_q <= count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign carry = carry_q;

endmodule

// File: rtl/display_frame_generator.sv
// display_frame_generator
// Builds a multi-digit 7-segment frame: the low field_digits positions show
// the decimal value (optionally with leading zeros blanked), the remaining
// positions show per-position label glyphs. One position can blink.
//   clock, reset_n   : system clock, asynchronous active-low reset
//   load             : one-cycle strobe latching a new frame description
//   value            : unsigned number to display
//   field_digits     : number of low positions used by the value (clamped)
//   label_code       : glyphs for positions at or above field_digits
//   lz_blank         : blank leading zeros in the value field
//   dp_mask          : decimal points of the frame
//   blink_en/pos     : live blink control, applied with one register stage
//   display_code/dp  : registered frame outputs, 6'h3F = blank
//   busy             : conversion running
//   done             : one-cycle pulse when a new frame is shown
//   overflow         : last frame's value did not fit its field
module display_frame_generator
    import display_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int VALUE_WIDTH = 32,
    parameter int BLINK_DIV   = 10000000
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         load,
    input  logic [VALUE_WIDTH-1:0]       value,
    input  logic [$clog2(DIGITS+1)-1:0]  field_digits,
    input  glyph_t [DIGITS-1:0]          label_code,
    input  logic                         lz_blank,
    input  logic [DIGITS-1:0]            dp_mask,
    input  logic                         blink_en,
    input  logic [$clog2(DIGITS)-1:0]    blink_pos,
    output glyph_t [DIGITS-1:0]          display_code,
    output logic [DIGITS-1:0]            display_dp,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int FW = $clog2(DIGITS + 1);
    localparam int PW = $clog2(DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic                  convBusy, convDone, convCarry;
    logic [DIGITS*4-1:0]   convBcd;

    logic [FW-1:0]         field_q;
    glyph_t [DIGITS-1:0]   label_q;
    logic                  lzBlank_q;
    logic [DIGITS-1:0]     dpMask_q;

    glyph_t [DIGITS-1:0]   frame_q, frame_d, newFrame;
    glyph_t [DIGITS-1:0]   code_q, code_d;
    logic [DIGITS-1:0]     dp_q;
    logic                  overflow_q, overflow_d;
    logic                  done_q;
    logic [BW-1:0]         blinkCnt_q;
    logic                  blinkPhase_q;

    logic                  seenNonzero;
    logic [3:0]            digit;

    bin2bcd_serial #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .DIGITS      (DIGITS)
    ) u_conv (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (load),
        .value   (value),
        .busy    (convBusy),
        .done    (convDone),
        .bcd     (convBcd),
        .carry   (convCarry)
    );

    // Frame assembly, scanned from the top position down so "seen a nonzero
    // digit yet" marks where leading-zero blanking stops. Digits that fall
    // outside the field only contribute to overflow.
    always_comb begin
        seenNonzero = 1'b0;
        overflow_d  = convCarry;
        newFrame    = '0;
        digit       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = convBcd[i*4 +: 4];
            if (FW'(i) < field_q) begin
                if (digit != 4'd0) begin
                    seenNonzero = 1'b1;
                end
                if (lzBlank_q && !seenNonzero && i != 0) begin
                    newFrame[i] = GLYPH_BLANK;
                end else begin
                    newFrame[i] = {2'b00, digit};
                end
            end else begin
                newFrame[i] = label_q[i];
                if (digit != 4'd0) begin
                    overflow_d = 1'b1;
                end
            end
        end
        frame_d = convDone ? newFrame : frame_q;
        code_d  = frame_d;
        for (int i = 0; i < DIGITS; i++) begin
            if (blink_en && blinkPhase_q && (blink_pos == PW'(i))) begin
                code_d[i] = GLYPH_BLANK;
            end
        end
    end

    // Input capture, frame commit on converter done, and the free-running
    // blink timebase. The blanked view is re-registered every cycle so blink
    // control acts live on the held frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            field_q      <= '0;
            label_q      <= {DIGITS{GLYPH_BLANK}};
            lzBlank_q    <= 1'b0;
            dpMask_q     <= '0;
            frame_q      <= {DIGITS{GLYPH_BLANK}};
            code_q       <= {DIGITS{GLYPH_BLANK}};
            dp_q         <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
        end else begin
            if (load) begin
                field_q   <= (field_digits > FW'(DIGITS)) ? FW'(DIGITS) : field_digits;
                label_q   <= label_code;
                lzBlank_q <= lz_blank;
                dpMask_q  <= dp_mask;
            end
            frame_q <= frame_d;
            code_q  <= code_d;
            done_q  <= convDone;
            if (convDone) begin
                dp_q       <= dpMask_q;
                overflow_q <= overflow_d;
            end
            if (blinkCnt_q == BW'(BLINK_DIV - 1)) begin
                blinkCnt_q   <= '0;
                blinkPhase_q <= ~blinkPhase_q;
            end else begin
                blinkCnt_q <= blinkCnt_q + BW'(1);
            end
        end
    end

    assign display_code = code_q;
    assign display_dp   = dp_q;
    assign busy         = convBusy;
    assign done         = done_q;
    assign overflow     = overflow_q;

endmodule
